// File: rtl/sys_cfg_bank_if.sv
// Bus bundle for sys_cfg_bank: PI-side config access, apply strobe and the
// decoded configuration outputs.
interface sys_cfg_bank_if #(
  parameter int REG_NUM = 8,
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 4,
  parameter int MSK_W   = 10
);
  logic                     ce;
  logic                     we;
  logic [ADDR_W-1:0]        addr;
  logic [REG_W-1:0]         dati;
  logic                     rd_act;
  logic                     apply_req;
  logic [REG_W-1:0]         dato;
  logic [REG_NUM*REG_W-1:0] cfg_act;
  logic [MSK_W-1:0]         rom_msk;
  logic [MSK_W-1:0]         brm_msk;
  logic                     pending;
  logic                     armed;
  logic                     cfg_upd;
  logic                     locked;

  modport master (
    output ce, we, addr, dati, rd_act, apply_req,
    input  dato, cfg_act, rom_msk, brm_msk, pending, armed, cfg_upd, locked
  );

  modport slave (
    input  ce, we, addr, dati, rd_act, apply_req,
    output dato, cfg_act, rom_msk, brm_msk, pending, armed, cfg_upd, locked
  );
endinterface

// File: rtl/sys_cfg_bank.sv
// Double-buffered config register bank: shadow written over PI, copied to the
// active bank on commit-now or on apply strobe. Write lock enabled by CFG_LOCK_EN.
module sys_cfg_bank #(
  parameter int REG_NUM = 8,
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 4,
  parameter int MSK_W   = 10,
  parameter int MSK_REG = 1
) (
  input logic           clk,
  input logic           rst,
  sys_cfg_bank_if.slave bus
);
  localparam int                IDX_W     = $clog2(REG_NUM);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(REG_NUM);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COPY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [REG_W-1:0] r_shadow [REG_NUM];
  logic [REG_W-1:0] r_active [REG_NUM];
  logic             r_pending;
  logic             r_cfg_upd;
  logic             w_wr_data;
  logic             w_wr_ctrl;
  logic             w_commit;
  logic             w_arm;
  logic             w_disarm;
  logic             w_locked;
  logic             w_do_copy;
  logic             w_changed;
  logic [IDX_W-1:0] w_idx;
  logic [REG_W-1:0] w_rd_data;

  // Bit i set while i < exponent; exponents >= MSK_W saturate to all ones.
  function automatic logic [MSK_W-1:0] f_sat_mask(input logic [3:0] exp_i);
    logic [MSK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MSK_W; i++)
      m[i] = (i < int'(exp_i));
    return m;
  endfunction

  assign w_idx     = bus.addr[IDX_W-1:0];
  assign w_wr_data = bus.ce & bus.we & (bus.addr < CTRL_ADDR);
  assign w_wr_ctrl = bus.ce & bus.we & (bus.addr == CTRL_ADDR);
  assign w_commit  = w_wr_ctrl & bus.dati[0];
  assign w_arm     = w_wr_ctrl & bus.dati[1];
  assign w_disarm  = w_wr_ctrl & bus.dati[3];
  assign w_do_copy = (r_state == S_COPY) & ~w_locked;

`ifdef CFG_LOCK_EN
  logic r_locked;
  always_ff @(posedge clk) begin
    if (rst)
      r_locked <= 1'b0;
    else if (w_wr_ctrl && bus.dati[2])
      r_locked <= 1'b1;
  end
  assign w_locked = r_locked;
`else
  assign w_locked = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_commit)   w_state_nxt = S_COPY;
        else if (w_arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_commit || bus.apply_req) w_state_nxt = S_COPY;
        else if (w_disarm)             w_state_nxt = S_IDLE;
      end
      S_COPY:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_changed = 1'b0;
    for (int i = 0; i < REG_NUM; i++)
      if (r_shadow[i] != r_active[i]) w_changed = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_cfg_upd <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_upd <= w_do_copy & w_changed;
      // A write landing during the copy keeps pending set.
      if (w_wr_data)      r_pending <= 1'b1;
      else if (w_do_copy) r_pending <= 1'b0;
    end
  end

  // The copy reads the pre-edge shadow, so a same-cycle write is not included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr_data)
        r_shadow[w_idx] <= bus.dati;
      if (w_do_copy)
        for (int i = 0; i < REG_NUM; i++)
          r_active[i] <= r_shadow[i];
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (bus.addr < CTRL_ADDR)
      w_rd_data = bus.rd_act ? r_active[w_idx] : r_shadow[w_idx];
    else if (bus.addr == CTRL_ADDR)
      w_rd_data[2:0] = {(r_state == S_ARMED), w_locked, r_pending};
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign bus.cfg_act[g*REG_W +: REG_W] = r_active[g];
  end

  assign bus.dato    = w_rd_data;
  assign bus.rom_msk = f_sat_mask(r_active[MSK_REG][3:0]);
  assign bus.brm_msk = f_sat_mask(r_active[MSK_REG][7:4]);
  assign bus.pending = r_pending;
  assign bus.armed   = (r_state == S_ARMED);
  assign bus.cfg_upd = r_cfg_upd;
  assign bus.locked  = w_locked;
endmodule

// File: tb/tb_sys_cfg_bank.sv
// Scoreboard bench for sys_cfg_bank: directed scenarios then random traffic,
// checked against a behavioural model of the shadow/active banks.
module tb_sys_cfg_bank;
  localparam int REG_NUM = 8;
  localparam int REG_W   = 8;
  localparam int ADDR_W  = 4;
  localparam int MSK_W   = 10;
  localparam int MSK_REG = 1;
`ifdef CFG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  dato;
    bit          pend;
    bit          armed;
    bit          lck;
    logic [63:0] act;
    logic [9:0]  rom;
    logic [9:0]  brm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference state: register banks as plain arrays plus commit bookkeeping.
  logic [7:0][7:0] m_sh;
  logic [7:0][7:0] m_act;
  bit   m_pend, m_armed, m_copy_due, m_lck;
  exp_t exp_q[$];
  int   upd_q[$];

  sys_cfg_bank_if #(.REG_NUM(REG_NUM), .REG_W(REG_W), .ADDR_W(ADDR_W), .MSK_W(MSK_W)) bus ();

  sys_cfg_bank #(
    .REG_NUM(REG_NUM), .REG_W(REG_W), .ADDR_W(ADDR_W), .MSK_W(MSK_W), .MSK_REG(MSK_REG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] ref_msk(input int e);
    if (e >= MSK_W) return 10'h3FF;
    return 10'((1 << e) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  task automatic model_step(input bit r, input bit wen, input logic [3:0] a,
                            input logic [7:0] d, input bit ap);
    bit wd, wc;
    wd = wen && (a < 4'd8);
    wc = wen && (a == 4'd8);
    if (r) begin
      m_sh = '0; m_act = '0;
      m_pend = 0; m_armed = 0; m_copy_due = 0; m_lck = 0;
      return;
    end
    if (m_copy_due) begin
      m_copy_due = 0;
      if (!m_lck) begin
        if (m_act != m_sh) upd_q.push_back(cyc + 1);
        m_act  = m_sh;
        m_pend = 0;
      end
    end else if (wc && d[0]) begin
      m_copy_due = 1; m_armed = 0;
    end else if (m_armed && ap) begin
      m_copy_due = 1; m_armed = 0;
    end else if (m_armed && wc && d[3]) begin
      m_armed = 0;
    end else if (wc && d[1]) begin
      m_armed = 1;
    end
    if (LOCK_EN && wc && d[2]) m_lck = 1;
    if (wd) begin
      m_sh[a[2:0]] = d;
      m_pend = 1;
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input bit ra, input bit ap);
    exp_t e;
    @(posedge clk); #1;
    rst = r; bus.ce = c; bus.we = w; bus.addr = a; bus.dati = d;
    bus.rd_act = ra; bus.apply_req = ap;
    if (a < 4'd8)       e.dato = ra ? m_act[a[2:0]] : m_sh[a[2:0]];
    else if (a == 4'd8) e.dato = {5'b0, m_armed, m_lck, m_pend};
    else                e.dato = 8'h00;
    e.pend  = m_pend;
    e.armed = m_armed;
    e.lck   = m_lck;
    e.act   = m_act;
    e.rom   = ref_msk(int'(m_act[MSK_REG][3:0]));
    e.brm   = ref_msk(int'(m_act[MSK_REG][7:4]));
    exp_q.push_back(e);
    model_step(r, c && w, a, d, ap);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    drive(0, 1, 1, a, d, 0, 0);
  endtask
  task automatic rd(input logic [3:0] a, input bit ra);
    drive(0, 1, 0, a, 8'h00, ra, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 4'h0, 8'h00, 0, 0);
  endtask

  // Monitor: compares every presented cycle and every cfg_upd pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dato",    bus.dato,    e.dato);
      chk("pending", bus.pending, e.pend);
      chk("armed",   bus.armed,   e.armed);
      chk("locked",  bus.locked,  e.lck);
      chk("cfg_act", bus.cfg_act, e.act);
      chk("rom_msk", bus.rom_msk, e.rom);
      chk("brm_msk", bus.brm_msk, e.brm);
      if (upd_q.size() > 0 && upd_q[0] == cyc) begin
        chk("cfg_upd_pulse", bus.cfg_upd, 1'b1);
        void'(upd_q.pop_front());
      end else begin
        chk("cfg_upd_quiet", bus.cfg_upd, 1'b0);
      end
    end
  end

  initial begin
    int sel;
    logic [7:0] d;
    logic [3:0] a;
    m_sh = '0; m_act = '0;
    m_pend = 0; m_armed = 0; m_copy_due = 0; m_lck = 0;
    bus.ce = 0; bus.we = 0; bus.addr = '0; bus.dati = '0;
    bus.rd_act = 0; bus.apply_req = 0;

    drive(1, 0, 0, 4'h0, 8'h00, 0, 0);
    drive(1, 0, 0, 4'h0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      rd(4'(i), 0);
      rd(4'(i), 1);
    end

    wr(4'd1, 8'h35); rd(4'd1, 0); rd(4'd1, 1); rd(4'd8, 0);
    wr(4'd8, 8'h01); idle(3); rd(4'd1, 1);

    wr(4'd2, 8'h66); wr(4'd8, 8'h02); idle(10);
    drive(0, 0, 0, 4'h0, 8'h00, 0, 1); idle(3);

    wr(4'd0, 8'h11); wr(4'd8, 8'h01); wr(4'd0, 8'hAA); idle(2);
    rd(4'd0, 1); rd(4'd0, 0); rd(4'd8, 0);

    wr(4'd1, 8'hFF); wr(4'd8, 8'h01); idle(3);
    wr(4'd8, 8'h01); idle(3);

    drive(0, 1, 1, 4'd8, 8'h02, 0, 1); idle(2);
    drive(0, 1, 1, 4'd8, 8'h08, 0, 1); idle(2);

    wr(4'd8, 8'h04); wr(4'd2, 8'h5A); wr(4'd8, 8'h01); idle(3);
    rd(4'd2, 1); rd(4'd8, 0);
    drive(1, 0, 0, 4'h0, 8'h00, 0, 0); idle(2);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      d   = 8'($urandom);
      a   = 4'($urandom_range(0, 15));
      if (sel < 2) begin
        drive(1, 0, 0, a, d, 0, 0);
      end else if (sel < 22) begin
        d[7:4] = 4'h0;
        if ($urandom_range(0, 199) != 0) d[2] = 1'b0;
        drive(0, 1, 1, 4'd8, d, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
      end else if (sel < 60) begin
        drive(0, $urandom_range(0, 9) != 0, 1, a, d, $urandom_range(0, 1) == 1,
              $urandom_range(0, 5) == 0);
      end else begin
        drive(0, $urandom_range(0, 1) == 1, 0, a, d, $urandom_range(0, 1) == 1,
              $urandom_range(0, 5) == 0);
      end
    end

    idle(4);
    @(negedge clk); #1;
    checks++;
    if (upd_q.size() != 0) begin
      errors++;
      $display("FAIL cfg_upd_outstanding got=%0d expected=0", upd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
